step_counter: RTL and testbench

- Parametrised sequential successor to the combinational word incrementer.
- Holds a WIDTH-bit count register and advances it by a programmable step, up or down, each enabled cycle.
- Three overflow modes: wrap, saturate, reload-at-limit.
- Reports a per-cycle carry/borrow, a terminal-count flag and a sticky overflow flag.
- Used by the pipeline for instruction-address sequencing, loop counts and interval timers.

---
 rtl/step_counter_pkg.sv | 17 +
 rtl/step_adder.sv | 24 ++
 rtl/step_counter.sv | 113 +++++++++++
 tb/tb_step_counter.sv | 161 ++++++++++++++++
 4 files changed

// File: rtl/step_counter_pkg.sv
// Shared constants for the step counter: default word length and overflow mode encodings.
// No logic, no latency.
// Imported by step_counter and its bench.
package step_counter_pkg;

  // Default datapath word length of the VCPU32 pipeline.
  localparam int WORD_LENGTH = 32;

  // Overflow handling modes; the reserved code falls back to wrap.
  typedef enum logic [1:0] {
    MODE_WRAP   = 2'd0,
    MODE_SAT    = 2'd1,
    MODE_RELOAD = 2'd2,
    MODE_RSVD   = 2'd3
  } mode_e;

endpackage

// File: rtl/step_adder.sv
// Combinational WIDTH-bit add/subtract with carry/borrow out.
// Zero latency.
// No flow control; purely combinational.
module step_adder #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             sub,
  output logic [WIDTH-1:0] s,
  output logic             outC
);

  logic [WIDTH:0] w_res;

  // One extra bit holds the carry (add) or borrow (subtract) of the unsigned operation.
  always_comb begin
    w_res = sub ? ({1'b0, a} - {1'b0, b}) : ({1'b0, a} + {1'b0, b});
  end

  assign s    = w_res[WIDTH-1:0];
  assign outC = w_res[WIDTH];

endmodule

// File: rtl/step_counter.sv
// Programmable-step up/down counter with wrap, saturate and reload-at-limit modes.
// One cycle from en/ld to the new count; tc is combinational on the registered count.
// No back-pressure; an update is accepted every cycle.
module step_counter
  import step_counter_pkg::*;
#(
  parameter int               WIDTH   = WORD_LENGTH,
  parameter int               STEP_W  = 4,
  parameter logic [WIDTH-1:0] RST_VAL = '0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              en,
  input  logic              ld,
  input  logic [WIDTH-1:0]  ldVal,
  input  logic [STEP_W-1:0] step,
  input  logic              dir,
  input  logic [1:0]        mode,
  input  logic [WIDTH-1:0]  limit,
  input  logic              clrOvf,
  // Count value; the VCPU32 manuals number the MSB as bit 0, which is cnt[WIDTH-1] here.
  output logic [WIDTH-1:0]  cnt,
  output logic              outC,
  output logic              tc,
  output logic              ovf
);

  logic [WIDTH-1:0] r_cnt;
  logic             r_outc;
  logic             r_ovf;

  logic [WIDTH-1:0] w_step_ext;
  logic [WIDTH-1:0] w_sum;
  logic             w_raw_c;
  logic [WIDTH-1:0] w_next;
  logic             w_next_c;
  logic             w_reload;
  logic             w_tc;
  logic             w_ovf_set;
  mode_e            w_mode;

  assign w_step_ext = WIDTH'(step);
  assign w_mode     = mode_e'(mode);
  assign w_tc       = (r_cnt == limit);

  step_adder #(
    .WIDTH (WIDTH)
  ) u_adder (
    .a    (r_cnt),
    .b    (w_step_ext),
    .sub  (dir),
    .s    (w_sum),
    .outC (w_raw_c)
  );

  // Mode selection: the next count and carry flag for an enabled update.
  always_comb begin
    w_next   = w_sum;
    w_next_c = w_raw_c;
    w_reload = 1'b0;
    case (w_mode)
      MODE_SAT: begin
        if (w_raw_c) begin
          w_next = dir ? '0 : '1;
        end
      end
      MODE_RELOAD: begin
        // Reaching the limit takes priority over stepping; the step is not applied.
        if (w_tc) begin
          w_reload = 1'b1;
          w_next   = ldVal;
          w_next_c = 1'b1;
        end
      end
      default: begin
      end
    endcase
  end

  // A genuine carry/borrow on an enabled step raises the sticky flag; limit reloads are expected events.
  assign w_ovf_set = en && !ld && w_raw_c && !w_reload;

  // Count register and flags: rst > ld > en > hold; a set of ovf beats a same-cycle clear.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_cnt  <= RST_VAL;
      r_outc <= 1'b0;
      r_ovf  <= 1'b0;
    end else begin
      if (ld) begin
        r_cnt  <= ldVal;
        r_outc <= 1'b0;
      end else if (en) begin
        r_cnt  <= w_next;
        r_outc <= w_next_c;
      end else begin
        r_outc <= 1'b0;
      end

      if (w_ovf_set) begin
        r_ovf <= 1'b1;
      end else if (clrOvf) begin
        r_ovf <= 1'b0;
      end
    end
  end

  assign cnt  = r_cnt;
  assign outC = r_outc;
  assign tc   = w_tc;
  assign ovf  = r_ovf;

endmodule

// File: tb/tb_step_counter.sv
// Directed bench for step_counter: a 32-bit instance driven from a vector table,
// plus hand-written sequences for combinational tc and an 8-bit / 2-bit-step instance.
module tb_step_counter;
  import step_counter_pkg::*;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  // 32-bit instance
  logic        rst, en, ld, dir, clrOvf;
  logic [31:0] ldVal, limit;
  logic [3:0]  step;
  logic [1:0]  mode;
  logic [31:0] cnt;
  logic        outC, tc, ovf;

  step_counter dut (
    .clk(clk), .rst(rst), .en(en), .ld(ld), .ldVal(ldVal), .step(step),
    .dir(dir), .mode(mode), .limit(limit), .clrOvf(clrOvf),
    .cnt(cnt), .outC(outC), .tc(tc), .ovf(ovf)
  );

  // 8-bit instance with a 2-bit step
  logic       n_rst, n_en, n_ld, n_dir, n_clr;
  logic [7:0] n_ldval, n_limit;
  logic [1:0] n_step;
  logic [1:0] n_mode;
  logic [7:0] n_cnt;
  logic       n_outc, n_tc, n_ovf;

  step_counter #(.WIDTH(8), .STEP_W(2), .RST_VAL(8'h00)) dut8 (
    .clk(clk), .rst(n_rst), .en(n_en), .ld(n_ld), .ldVal(n_ldval), .step(n_step),
    .dir(n_dir), .mode(n_mode), .limit(n_limit), .clrOvf(n_clr),
    .cnt(n_cnt), .outC(n_outc), .tc(n_tc), .ovf(n_ovf)
  );

  typedef struct {
    logic        rst, ld, en;
    logic [31:0] ldval;
    logic [3:0]  step;
    logic        dir;
    logic [1:0]  mode;
    logic [31:0] limit;
    logic        clr;
    logic [31:0] e_cnt;
    logic        e_c, e_ovf, e_tc;
  } vec_t;

  vec_t vq[$];
  int   n_chk  = 0;
  int   n_pass = 0;

  localparam logic [31:0] L = 32'hDEAD_0000;

  function automatic void addv(input logic r, input logic l, input logic e, input logic [31:0] lv,
                               input logic [3:0] s, input logic d, input logic [1:0] m,
                               input logic [31:0] lim, input logic c, input logic [31:0] ec,
                               input logic eo, input logic eovf, input logic etc);
    vec_t v;
    v.rst = r; v.ld = l; v.en = e; v.ldval = lv; v.step = s; v.dir = d; v.mode = m;
    v.limit = lim; v.clr = c; v.e_cnt = ec; v.e_c = eo; v.e_ovf = eovf; v.e_tc = etc;
    vq.push_back(v);
  endfunction

  task automatic chk(input string nm, input int idx, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s[%0d]: got %h expected %h", nm, idx, act, exp);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b0; en = 1'b0; ld = 1'b0; dir = 1'b0; clrOvf = 1'b0;
    ldVal = '0; limit = L; step = '0; mode = 2'd0;
    n_rst = 1'b0; n_en = 1'b0; n_ld = 1'b0; n_dir = 1'b0; n_clr = 1'b0;
    n_ldval = '0; n_limit = 8'h80; n_step = '0; n_mode = 2'd0;

    //    rst ld en  ldVal         stp dir mode limit          clr  cnt           c  ovf tc
    addv(1, 0, 0, 32'h0,         0, 0, 0, L,             0, 32'h0,         0, 0, 0); // reset
    addv(0, 0, 1, 32'h0,         1, 0, 0, L,             0, 32'h1,         0, 0, 0); // up by 1
    addv(0, 0, 1, 32'h0,         1, 0, 0, L,             0, 32'h2,         0, 0, 0);
    addv(0, 0, 1, 32'h0,         1, 0, 0, L,             0, 32'h3,         0, 0, 0);
    addv(0, 1, 0, 32'hFFFFFFFE,  0, 0, 0, L,             0, 32'hFFFFFFFE,  0, 0, 0); // load near top
    addv(0, 0, 1, 32'h0,         3, 0, 0, L,             0, 32'h1,         1, 1, 0); // wrap up
    addv(0, 0, 0, 32'h0,         3, 0, 0, L,             0, 32'h1,         0, 1, 0); // hold: carry drops, ovf sticky
    addv(0, 0, 0, 32'h0,         0, 0, 0, L,             1, 32'h1,         0, 0, 0); // clear ovf
    addv(0, 1, 0, 32'hFFFFFFFD,  0, 0, 1, L,             0, 32'hFFFFFFFD,  0, 0, 0);
    addv(0, 0, 1, 32'h0,         5, 0, 1, L,             0, 32'hFFFFFFFF,  1, 1, 0); // saturate up
    addv(0, 1, 0, 32'h2,         0, 0, 1, L,             1, 32'h2,         0, 0, 0); // ld + clear
    addv(0, 0, 1, 32'h0,         5, 1, 1, L,             0, 32'h0,         1, 1, 0); // saturate down
    addv(0, 0, 0, 32'h0,         0, 0, 0, L,             1, 32'h0,         0, 0, 0);
    addv(0, 1, 0, 32'h10,        1, 0, 2, 32'h12,        0, 32'h10,        0, 0, 0); // reload mode
    addv(0, 0, 1, 32'h10,        1, 0, 2, 32'h12,        0, 32'h11,        0, 0, 0);
    addv(0, 0, 1, 32'h10,        1, 0, 2, 32'h12,        0, 32'h12,        0, 0, 1); // at limit
    addv(0, 0, 1, 32'h10,        1, 0, 2, 32'h12,        0, 32'h10,        1, 0, 0); // reload, no ovf
    addv(0, 0, 0, 32'h10,        1, 0, 2, 32'h12,        0, 32'h10,        0, 0, 0);
    addv(0, 1, 1, 32'h55,        1, 0, 0, L,             0, 32'h55,        0, 0, 0); // ld beats en
    addv(1, 1, 0, 32'h77,        0, 0, 0, L,             0, 32'h0,         0, 0, 0); // rst beats ld
    addv(0, 1, 0, 32'hFFFFFFFF,  0, 0, 0, L,             0, 32'hFFFFFFFF,  0, 0, 0);
    addv(0, 0, 1, 32'h0,         1, 0, 0, L,             1, 32'h0,         1, 1, 0); // set beats clear
    addv(0, 0, 1, 32'h0,         0, 0, 0, L,             0, 32'h0,         0, 1, 0); // step 0 holds
    addv(0, 0, 1, 32'h0,         2, 1, 3, L,             0, 32'hFFFFFFFE,  1, 1, 0); // reserved mode wraps
    addv(0, 0, 1, 32'h33,        0, 0, 2, 32'hFFFFFFFE,  0, 32'h33,        1, 1, 0); // step 0 still reloads
    addv(1, 0, 1, 32'h0,         7, 0, 0, L,             0, 32'h0,         0, 0, 0); // reset mid-sequence
    addv(0, 0, 1, 32'h0,         4, 0, 1, L,             0, 32'h4,         0, 0, 0); // restart from RST_VAL

    @(negedge clk);
    for (int i = 0; i < vq.size(); i++) begin
      rst = vq[i].rst; ld = vq[i].ld; en = vq[i].en; ldVal = vq[i].ldval;
      step = vq[i].step; dir = vq[i].dir; mode = vq[i].mode; limit = vq[i].limit;
      clrOvf = vq[i].clr;
      @(posedge clk);
      @(negedge clk);
      chk("cnt",  i, cnt,          vq[i].e_cnt);
      chk("outC", i, {31'b0, outC}, {31'b0, vq[i].e_c});
      chk("ovf",  i, {31'b0, ovf},  {31'b0, vq[i].e_ovf});
      chk("tc",   i, {31'b0, tc},   {31'b0, vq[i].e_tc});
    end

    // tc follows limit combinationally, with no clock edge and no count change
    rst = 1'b0; ld = 1'b0; en = 1'b0; clrOvf = 1'b0;
    limit = 32'h4;
    #1;
    chk("tc_comb_hit", 0, {31'b0, tc}, 32'h1);
    limit = 32'h5;
    #1;
    chk("tc_comb_miss", 0, {31'b0, tc}, 32'h0);
    chk("cnt_no_edge",  0, cnt, 32'h4);

    // 8-bit instance: down-count across zero with a 2-bit step, then step 0
    @(negedge clk);
    n_rst = 1'b1;
    @(posedge clk); @(negedge clk);
    chk("n_rst_cnt", 0, {24'b0, n_cnt}, 32'h00);
    chk("n_rst_ovf", 0, {31'b0, n_ovf}, 32'h0);
    n_rst = 1'b0; n_ld = 1'b1; n_ldval = 8'h01;
    @(posedge clk); @(negedge clk);
    chk("n_ld_cnt", 0, {24'b0, n_cnt}, 32'h01);
    n_ld = 1'b0; n_en = 1'b1; n_dir = 1'b1; n_step = 2'd3; n_mode = 2'd0; n_limit = 8'hFE;
    @(posedge clk); @(negedge clk);
    chk("n_wrap_cnt",  0, {24'b0, n_cnt},  32'hFE);
    chk("n_wrap_outC", 0, {31'b0, n_outc}, 32'h1);
    chk("n_wrap_ovf",  0, {31'b0, n_ovf},  32'h1);
    chk("n_wrap_tc",   0, {31'b0, n_tc},   32'h1);
    n_step = 2'd0;
    @(posedge clk); @(negedge clk);
    chk("n_step0_cnt",  0, {24'b0, n_cnt},  32'hFE);
    chk("n_step0_outC", 0, {31'b0, n_outc}, 32'h0);
    chk("n_step0_ovf",  0, {31'b0, n_ovf},  32'h1);
    n_en = 1'b0;

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
